// File: rtl/fft32_pkg.sv
// Shared constants, stage-offset helper and sequencer states for the
// 32-point MDC FFT commutator controller.
package fft32_pkg;

  localparam int unsigned N_PTS = 32;
  localparam int unsigned N_STG = 5;
  localparam int unsigned PIPE  = 1;
  localparam int unsigned OFF_W = 6;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_DRAIN_WAIT,
    ST_FLUSH
  } state_e;

  // Advance count at which the first sample reaches stage k.
  function automatic int unsigned stage_off(input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned i = 1; i <= k; i++) begin
      off += ((N_PTS / 2) >> (i - 1)) + PIPE;
    end
    return off;
  endfunction

endpackage

// File: rtl/fft32_commutator_ctrl_stage_cnt.sv
// Per-stage sample counter and commutator-enable bit; clear beats set,
// set beats counting.
module stage_cnt
  import fft32_pkg::*;
#(
  parameter logic [CNT_W-1:0] SET_CNT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             set,
  input  logic             clr,
  output logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic             mode_d, mode_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    if (clr) begin
      mode_d = 1'b0;
      cnt_d  = '0;
    end else if (set) begin
      mode_d = 1'b1;
      cnt_d  = SET_CNT;
    end else if (step && mode_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mode = mode_q;
  assign cnt  = cnt_q;
  assign wrap = step & mode_q & (cnt_q == '1);

endmodule

// File: rtl/fft32_commutator_ctrl.sv
// Sequencer for the five MDC commutator stages: fill tracking, steady-state
// streaming and frame-aligned end-of-stream flush.
module fft32_commutator_ctrl
  import fft32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             flush_req,
  output logic             adv,
  output logic [N_STG-1:0] state_com_mode,
  output logic [6:0]       com_mask,
  output logic             frame_start,
  output logic             out_frame_start,
  output logic             busy
);

  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(stage_off(N_STG - 1));

  state_e           state_q, state_d;
  logic [OFF_W-1:0] fcnt_q, fcnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic [N_STG-1:0] mode, set, clr, wrap;
  logic [CNT_W-1:0] cnt [N_STG];
  logic             streaming, flushing, take;

  assign streaming = state_q inside {ST_FILL, ST_RUN, ST_DRAIN_WAIT};
  assign flushing  = (state_q == ST_FLUSH);
  // A pending request is honoured only on a stage-0 frame boundary.
  assign take      = streaming & (flush_pend_q | flush_req) &
                     ((cnt[0] == '0) | wrap[0]);

  for (genvar k = 0; k < N_STG; k++) begin : g_stage
    stage_cnt #(
      .SET_CNT(CNT_W'(k == 0 ? 1 : 0))
    ) u_stage (
      .clk  (clk),
      .rst_n(rst_n),
      .step (adv),
      .set  (set[k]),
      .clr  (clr[k]),
      .mode (mode[k]),
      .cnt  (cnt[k]),
      .wrap (wrap[k])
    );
  end

  always_comb begin
    set    = '0;
    clr    = '0;
    set[0] = (state_q == ST_IDLE) & in_valid;
    clr[0] = take;
    // Activation keeps running during a flush so a partial frame drains fully.
    for (int unsigned k = 1; k < N_STG; k++) begin
      set[k] = adv & ~mode[k] & (fcnt_q == OFF_W'(stage_off(k) - 1));
      clr[k] = flushing & wrap[k] & ~mode[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (in_valid) state_d = ST_FILL;
      ST_FILL: begin
        if (take)                  state_d = ST_FLUSH;
        else if (flush_req)        state_d = ST_DRAIN_WAIT;
        else if (set[N_STG-1])     state_d = ST_RUN;
      end
      ST_RUN: begin
        if (take)                  state_d = ST_FLUSH;
        else if (flush_req)        state_d = ST_DRAIN_WAIT;
      end
      ST_DRAIN_WAIT: if (take) state_d = ST_FLUSH;
      ST_FLUSH:      if (clr[N_STG-1]) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fcnt_d       = fcnt_q;
    flush_pend_d = flush_pend_q;
    if (state_d == ST_IDLE)                  fcnt_d = '0;
    else if (state_q == ST_IDLE)             fcnt_d = OFF_W'(1);
    else if (adv && (fcnt_q != OFF_LAST))    fcnt_d = fcnt_q + 1'b1;
    if (!streaming || take)                  flush_pend_d = 1'b0;
    else if (flush_req)                      flush_pend_d = 1'b1;
  end

  always_comb begin
    adv             = (streaming & in_valid) | flushing;
    busy            = (state_q != ST_IDLE);
    state_com_mode  = mode;
    frame_start     = adv & mode[0] & (cnt[0] == '0);
    out_frame_start = adv & mode[N_STG-1] & (cnt[N_STG-1] == '0);
    com_mask        = '0;
    for (int unsigned k = 0; k < N_STG; k++) begin
      com_mask[k] = cnt[k][CNT_W-1-k];
    end
  end

endmodule

// File: tb/tb_fft32_commutator_ctrl.sv
// Randomized bench for fft32_commutator_ctrl against an advance-count model
// of the stage timing, fill and flush drain.
module tb_fft32_commutator_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       flush_req;
  logic       adv;
  logic [4:0] state_com_mode;
  logic [6:0] com_mask;
  logic       frame_start;
  logic       out_frame_start;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int ofs_seen = 0;

  // Model: m_n counts advances since the frame's first sample.
  int off [5];
  bit m_busy, m_flush, m_pend;
  int m_n;
  int m_d [5];

  always #5 clk = ~clk;

  fft32_commutator_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .flush_req      (flush_req),
    .adv            (adv),
    .state_com_mode (state_com_mode),
    .com_mask       (com_mask),
    .frame_start    (frame_start),
    .out_frame_start(out_frame_start),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_mode(input int k);
    if (!m_busy) return 1'b0;
    if (k == 0) return !m_flush;
    return (m_n >= off[k]) && (!m_flush || (m_n < m_d[k]));
  endfunction

  function automatic int m_cnt(input int k);
    if (!m_mode(k)) return 0;
    return (k == 0) ? (m_n % 32) : ((m_n - off[k]) % 32);
  endfunction

  task automatic m_reset();
    m_busy = 0; m_flush = 0; m_pend = 0; m_n = 0;
  endtask

  // Stage k stops after the first wrap that follows stage k-1 going quiet.
  task automatic set_drain(input int e);
    int lo, x;
    m_d[0] = e;
    for (int k = 1; k < 5; k++) begin
      lo = (m_d[k-1] > off[k]) ? m_d[k-1] : off[k];
      x  = lo + 1;
      while (((x - off[k]) % 32) != 0) x++;
      m_d[k] = x;
    end
  endtask

  task automatic m_step(input bit v, input bit f);
    if (!m_busy) begin
      if (v) begin m_busy = 1; m_n = 1; m_flush = 0; m_pend = 0; end
    end else if (m_flush) begin
      m_n++;
      if (m_n == m_d[4]) m_reset();
    end else if ((m_pend || f) && (((m_n % 32) == 0) || (v && ((m_n % 32) == 31)))) begin
      m_flush = 1; m_pend = 0;
      m_n += int'(v);
      set_drain(m_n);
    end else begin
      if (f) m_pend = 1;
      m_n += int'(v);
    end
  endtask

  task automatic check_outputs();
    logic [4:0] em;
    logic [6:0] emask;
    bit         eadv;
    emask = '0;
    for (int k = 0; k < 5; k++) begin
      em[k]    = m_mode(k);
      emask[k] = ((m_cnt(k) >> (4 - k)) & 1) != 0;
    end
    eadv = m_busy && (m_flush || in_valid);
    chk("adv",             32'(adv),             32'(eadv));
    chk("state_com_mode",  32'(state_com_mode),  32'(em));
    chk("com_mask",        32'(com_mask),        32'(emask));
    chk("busy",            32'(busy),            32'(m_busy));
    chk("frame_start",     32'(frame_start),     32'(eadv && em[0] && m_cnt(0) == 0));
    chk("out_frame_start", 32'(out_frame_start), 32'(eadv && em[4] && m_cnt(4) == 0));
  endtask

  task automatic cycle(input bit v, input bit f);
    @(negedge clk);
    in_valid  = v;
    flush_req = f;
    #1;
    check_outputs();
    if (out_frame_start) ofs_seen++;
    m_step(v, f);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".adv"},  32'(adv),             0);
    chk({tag, ".mode"}, 32'(state_com_mode),  0);
    chk({tag, ".mask"}, 32'(com_mask),        0);
    chk({tag, ".fs"},   32'(frame_start),     0);
    chk({tag, ".ofs"},  32'(out_frame_start), 0);
    chk({tag, ".busy"}, 32'(busy),            0);
  endtask

  // Feed random-valid cycles until the model has seen `target` advances.
  task automatic feed(input int target, input int unsigned pct);
    int guard = 0;
    while (m_n < target && guard < 2000) begin
      cycle($urandom_range(99) < pct, 1'b0);
      guard++;
    end
    chk("feed.bound", 32'(guard < 2000), 1);
  endtask

  task automatic drain(input int unsigned pct);
    int guard = 0;
    while (m_busy && guard < 400) begin
      cycle($urandom_range(99) < pct, 1'b0);
      guard++;
    end
    chk("drain.bound", 32'(guard < 400), 1);
    @(negedge clk);
    in_valid  = 1'b0;
    flush_req = 1'b0;
    #1;
    chk("drain.busy", 32'(busy),           0);
    chk("drain.mask", 32'(com_mask),       0);
    chk("drain.mode", 32'(state_com_mode), 0);
    m_step(1'b0, 1'b0);
  endtask

  initial begin
    off[0] = 0;
    for (int k = 1; k < 5; k++) off[k] = off[k-1] + (16 >> (k - 1)) + 1;
    rst_n = 1'b0; in_valid = 1'b0; flush_req = 1'b0;
    m_reset();
    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    chk("idle_flush.busy", 32'(busy), 0);

    ofs_seen = 0;
    repeat (100) cycle(1'b1, 1'b0);
    chk("run100.ofs_pulses", 32'(ofs_seen), 3);
    chk("run100.mode", 32'(state_com_mode), 5'h1f);
    cycle(1'b1, 1'b1);
    drain(100);

    for (int i = 0; m_n < 64 && i < 400; i++) cycle((i % 4) == 0 || (i % 4) == 3, 1'b0);
    cycle(1'b1, 1'b1);
    drain(50);

    feed(39, 70);
    cycle(1'b1, 1'b1);
    drain(70);

    feed(9, 70);
    cycle(1'b1, 1'b1);
    drain(60);

    feed(64, 100);
    cycle(1'b0, 1'b1);
    drain(80);

    feed(96, 90);
    cycle(1'b1, 1'b1);
    drain(80);

    repeat (6) begin
      feed($urandom_range(1, 120), $urandom_range(40, 100));
      cycle($urandom_range(1) == 1, 1'b1);
      drain($urandom_range(0, 100));
    end

    feed(50, 100);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    m_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    chk("restart.mode", 32'(state_com_mode), 5'h01);
    feed(40, 80);
    cycle(1'b1, 1'b1);
    drain(90);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
